// File: rtl/uart_regs_pkg.sv
// Shared register map for the UART AHB-Lite register block: word offsets,
// CTRL field positions and ISR bit indices.
package uart_regs_pkg;

  // Word offset decoded from HADDR[3:2].
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_ISR    = 2'd3
  } reg_sel_e;

  localparam int CTRL_W          = 10;
  localparam int CTRL_UART_EN    = 0;
  localparam int CTRL_IRQ_EN_LSB = 4;
  localparam int CTRL_IRQ_EN_W   = 4;
  localparam int CTRL_TXBAUD     = 8;
  localparam int CTRL_RXBAUD     = 9;

  localparam int ISR_W    = 4;
  localparam int ISR_RX   = 0;
  localparam int ISR_TX   = 1;
  localparam int ISR_RXNE = 2;
  localparam int ISR_TXE  = 3;

endpackage

// File: rtl/uart_irq_capture.sv
// Sticky per-source UART interrupt flags with write-1-to-clear and a
// registered, enable-masked interrupt output. Used only with UART_REGS_IRQ_STATUS_EN.
module uart_irq_capture
  import uart_regs_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     txfifo_empty,
  input  logic                     rxfifo_empty,
  input  logic                     tx_flag,
  input  logic                     rx_flag,
  input  logic [ISR_W-1:0]         clr,
  input  logic [CTRL_IRQ_EN_W-1:0] irq_en,
  output logic [ISR_W-1:0]         isr,
  output logic                     irq
);

  logic txe_q;
  logic rxe_q;
  logic tx_q;
  logic rx_q;
  logic [ISR_W-1:0] set;

  always_comb begin
    set           = '0;
    set[ISR_TXE]  = txfifo_empty & ~txe_q;
    set[ISR_RXNE] = ~rxfifo_empty & rxe_q;
    set[ISR_TX]   = tx_flag & ~tx_q;
    set[ISR_RX]   = rx_flag & ~rx_q;
  end

  // Edge history resets to the idle UART state so leaving reset is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txe_q <= 1'b1;
      rxe_q <= 1'b1;
      tx_q  <= 1'b0;
      rx_q  <= 1'b0;
      isr   <= '0;
      irq   <= 1'b0;
    end else begin
      txe_q <= txfifo_empty;
      rxe_q <= rxfifo_empty;
      tx_q  <= tx_flag;
      rx_q  <= rx_flag;
      isr   <= (isr & ~clr) | set;
      irq   <= |(isr & irq_en);
    end
  end

endmodule

// File: rtl/ahb_uart_regs.sv
// AHB-Lite register slave in front of uart_top: DATA/STATUS/CTRL/ISR.
// Build option UART_REGS_IRQ_STATUS_EN enables the sticky ISR; otherwise irq follows uart_irq.
module ahb_uart_regs
  import uart_regs_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              uart_en,
  output logic [3:0]        irq_en,
  output logic              txbaud,
  output logic              rxbaud,
  output logic              wr_txfifo,
  output logic [7:0]        wrdata,
  output logic              rd_rxfifo,
  input  logic [7:0]        rddata,
  input  logic              txfifo_empty,
  input  logic              rxfifo_empty,
  input  logic              tx_flag,
  input  logic              rx_flag,
  input  logic              uart_irq,
  output logic              irq
);

  logic              dp_valid;
  logic              dp_write;
  reg_sel_e          dp_sel;
  logic              dp_wr;
  logic              dp_rd;
  logic [CTRL_W-1:0] ctrl;
  logic [ISR_W-1:0]  isr;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_sel   <= REG_DATA;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_sel   <= reg_sel_e'(HADDR[3:2]);
    end
  end

  assign dp_wr = dp_valid & dp_write;
  assign dp_rd = dp_valid & ~dp_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl      <= '0;
      wr_txfifo <= 1'b0;
      wrdata    <= '0;
    end else begin
      wr_txfifo <= dp_wr && (dp_sel == REG_DATA);
      if (dp_wr && (dp_sel == REG_DATA)) wrdata <= HWDATA[7:0];
      if (dp_wr && (dp_sel == REG_CTRL)) ctrl <= HWDATA[CTRL_W-1:0];
    end
  end

  assign uart_en = ctrl[CTRL_UART_EN];
  assign irq_en  = ctrl[CTRL_IRQ_EN_LSB +: CTRL_IRQ_EN_W];
  assign txbaud  = ctrl[CTRL_TXBAUD];
  assign rxbaud  = ctrl[CTRL_RXBAUD];

  // The pop is issued in the data phase itself; the FIFO head advances at the next edge.
  assign rd_rxfifo = dp_rd && (dp_sel == REG_DATA) && !rxfifo_empty;

  // NOTE: HRDATA gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    HRDATA = '0;
    if (dp_rd) begin
      unique case (dp_sel)
        REG_DATA:   if (!rxfifo_empty) HRDATA[7:0] = rddata;
        REG_STATUS: HRDATA[3:0] = {rx_flag, tx_flag, rxfifo_empty, txfifo_empty};
        REG_CTRL:   HRDATA[CTRL_W-1:0] = ctrl;
        REG_ISR:    HRDATA[ISR_W-1:0] = isr;
        default:    HRDATA = '0;
      endcase
    end
  end

  logic unused_bus;
  assign unused_bus = ^{HWDATA[31:CTRL_W], HADDR[ADDR_W-1:4], HADDR[1:0], HTRANS[0]};

`ifdef UART_REGS_IRQ_STATUS_EN
  logic [ISR_W-1:0] isr_clr;
  logic             unused_irq;

  assign isr_clr    = (dp_wr && (dp_sel == REG_ISR)) ? HWDATA[ISR_W-1:0] : '0;
  assign unused_irq = uart_irq;

  uart_irq_capture u_irq_capture (
    .clk          (clk),
    .rst          (rst),
    .txfifo_empty (txfifo_empty),
    .rxfifo_empty (rxfifo_empty),
    .tx_flag      (tx_flag),
    .rx_flag      (rx_flag),
    .clr          (isr_clr),
    .irq_en       (irq_en),
    .isr          (isr),
    .irq          (irq)
  );
`else
  assign isr = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= uart_irq;
  end
`endif

endmodule

// File: tb/tb_ahb_uart_regs.sv
// Self-checking bench for ahb_uart_regs: a transaction-level model plus a
// per-cycle compare process, with literal checks that pin the model.
module tb_ahb_uart_regs;

  localparam int ADDR_W = 12;
  localparam int NCYC   = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              HSEL = 1'b0;
  logic              HWRITE = 1'b0;
  logic              HREADY = 1'b1;
  logic [1:0]        HTRANS = 2'b00;
  logic [ADDR_W-1:0] HADDR = '0;
  logic [31:0]       HWDATA = '0;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic              uart_en;
  logic [3:0]        irq_en;
  logic              txbaud;
  logic              rxbaud;
  logic              wr_txfifo;
  logic [7:0]        wrdata;
  logic              rd_rxfifo;
  logic [7:0]        rddata;
  logic              txfifo_empty = 1'b1;
  logic              rxfifo_empty;
  logic              tx_flag = 1'b0;
  logic              rx_flag = 1'b0;
  logic              uart_irq = 1'b0;
  logic              irq;

  ahb_uart_regs #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .HSEL         (HSEL),
    .HWRITE       (HWRITE),
    .HREADY       (HREADY),
    .HTRANS       (HTRANS),
    .HADDR        (HADDR),
    .HWDATA       (HWDATA),
    .HRDATA       (HRDATA),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .uart_en      (uart_en),
    .irq_en       (irq_en),
    .txbaud       (txbaud),
    .rxbaud       (rxbaud),
    .wr_txfifo    (wr_txfifo),
    .wrdata       (wrdata),
    .rd_rxfifo    (rd_rxfifo),
    .rddata       (rddata),
    .txfifo_empty (txfifo_empty),
    .rxfifo_empty (rxfifo_empty),
    .tx_flag      (tx_flag),
    .rx_flag      (rx_flag),
    .uart_irq     (uart_irq),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Show-ahead RX FIFO environment; stale entries are left non-zero on purpose.
  logic [7:0] rx_mem [16];
  logic [3:0] rx_head = '0;
  logic [3:0] rx_tail = '0;
  assign rddata       = rx_mem[rx_head];
  assign rxfifo_empty = (rx_head == rx_tail);
  always @(posedge clk) if (rd_rxfifo && !rxfifo_empty) rx_head <= rx_head + 4'd1;

  // Per-cycle expectations, filled in by the driver when a transfer is issued.
  bit         exp_push     [NCYC];
  logic [7:0] exp_wbyte    [NCYC];
  bit         exp_ctrl_set [NCYC];
  logic [9:0] exp_ctrl_val [NCYC];
  bit         exp_pop      [NCYC];
  int         rd_sel       [NCYC];
  logic [7:0] rd_byte      [NCYC];
`ifdef UART_REGS_IRQ_STATUS_EN
  logic [3:0] exp_clr      [NCYC];
`endif
  logic [7:0] rx_model [$];

  function automatic void clear_from(input int from);
    for (int i = from; i < NCYC; i++) begin
      exp_push[i]     = 1'b0;
      exp_wbyte[i]    = '0;
      exp_ctrl_set[i] = 1'b0;
      exp_ctrl_val[i] = '0;
      exp_pop[i]      = 1'b0;
      rd_sel[i]       = 0;
      rd_byte[i]      = '0;
`ifdef UART_REGS_IRQ_STATUS_EN
      exp_clr[i]      = '0;
`endif
    end
  endfunction

  // Model state as seen in the current cycle.
  logic [9:0]  m_ctrl;
  logic [7:0]  m_wbyte;
  logic        m_irq;
  logic [31:0] m_rd;
`ifdef UART_REGS_IRQ_STATUS_EN
  logic [3:0]  m_isr;
  logic [3:0]  m_set;
  logic        p_txe, p_rxe, p_tx, p_rx;
`endif

  always @(negedge clk) begin : compare
    if (rst) begin
      check("reset_outputs",
            {wr_txfifo, rd_rxfifo, uart_en, irq_en, txbaud, rxbaud, irq, HRESP, wrdata}, 32'h0);
      check("reset_hrdata", HRDATA, 32'h0);
      check("reset_hreadyout", HREADYOUT, 32'h1);
      m_ctrl  = '0;
      m_wbyte = '0;
      m_irq   = 1'b0;
`ifdef UART_REGS_IRQ_STATUS_EN
      m_isr = '0;
      p_txe = 1'b1;
      p_rxe = 1'b1;
      p_tx  = 1'b0;
      p_rx  = 1'b0;
`endif
    end else begin
      if (exp_push[cyc])     m_wbyte = exp_wbyte[cyc];
      if (exp_ctrl_set[cyc]) m_ctrl  = exp_ctrl_val[cyc];
      case (rd_sel[cyc])
        1:       m_rd = {24'h0, rd_byte[cyc]};
        2:       m_rd = {28'h0, rx_flag, tx_flag, rxfifo_empty, txfifo_empty};
        3:       m_rd = {22'h0, m_ctrl};
`ifdef UART_REGS_IRQ_STATUS_EN
        4:       m_rd = {28'h0, m_isr};
`endif
        default: m_rd = 32'h0;
      endcase
      check("wr_txfifo", wr_txfifo, exp_push[cyc]);
      check("wrdata", wrdata, m_wbyte);
      check("rd_rxfifo", rd_rxfifo, exp_pop[cyc]);
      check("hrdata", HRDATA, m_rd);
      check("ctrl_outputs", {rxbaud, txbaud, irq_en, uart_en}, {m_ctrl[9:4], m_ctrl[0]});
      check("irq", irq, m_irq);
      check("hready_hresp", {HREADYOUT, HRESP}, 32'h2);
`ifdef UART_REGS_IRQ_STATUS_EN
      m_set = {txfifo_empty & ~p_txe, ~rxfifo_empty & p_rxe, tx_flag & ~p_tx, rx_flag & ~p_rx};
      m_irq = |(m_isr & m_ctrl[7:4]);
      m_isr = (m_isr & ~exp_clr[cyc]) | m_set;
      p_txe = txfifo_empty;
      p_rxe = rxfifo_empty;
      p_tx  = tx_flag;
      p_rx  = rx_flag;
`else
      m_irq = uart_irq;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address phase now, data phase on return; back-to-back calls pipeline naturally.
  task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    int p;
    logic [1:0] off;
    p   = cyc;
    off = addr[3:2];
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR  = addr;
    if (wr) begin
      case (off)
        2'd0: begin exp_push[p+2] = 1'b1; exp_wbyte[p+2] = wdata[7:0]; end
        2'd2: begin exp_ctrl_set[p+2] = 1'b1; exp_ctrl_val[p+2] = wdata[9:0]; end
`ifdef UART_REGS_IRQ_STATUS_EN
        2'd3: exp_clr[p+1] = wdata[3:0];
`endif
        default: ;
      endcase
    end else begin
      rd_sel[p+1] = int'(off) + 1;
      if (off == 2'd0 && rx_model.size() > 0) begin
        rd_byte[p+1] = rx_model.pop_front();
        exp_pop[p+1] = 1'b1;
      end
    end
    tick();
    HWDATA = wdata;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_tail] = b;
    rx_tail = rx_tail + 4'd1;
    rx_model.push_back(b);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    clear_from(cyc);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) rx_mem[i] = 8'hEE;
    clear_from(0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_reset_hreadyout", HREADYOUT, 32'h1);
    check("lit_reset_ctrl", {rxbaud, txbaud, irq_en, uart_en}, 32'h0);
    tick();

    // TX push: pulse two cycles after the address phase.
    xfer(1'b1, 12'h000, 32'h1234_56A5);
    @(negedge clk); check("lit_tx_no_early_push", wr_txfifo, 32'h0);
    tick();
    @(negedge clk); check("lit_tx_push", wr_txfifo, 32'h1); check("lit_tx_byte", wrdata, 32'hA5);
    tick();
    @(negedge clk); check("lit_tx_single_pulse", wr_txfifo, 32'h0);
    tick();

    // RX pop, then a read with the FIFO empty (stale head is 0xEE).
    push_rx(8'h3C);
    tick();
    xfer(1'b0, 12'h000, 32'hDEAD_BEEF);
    @(negedge clk); check("lit_rx_data", HRDATA, 32'h3C); check("lit_rx_pop", rd_rxfifo, 32'h1);
    tick();
    tick();
    xfer(1'b0, 12'h000, 32'hDEAD_BEEF);
    @(negedge clk); check("lit_rx_empty_data", HRDATA, 32'h0); check("lit_rx_empty_no_pop", rd_rxfifo, 32'h0);
    tick();

    // CTRL write immediately followed by its read-back.
    xfer(1'b1, 12'h008, 32'hFFFF_F3F1);
    xfer(1'b0, 12'h008, 32'hDEAD_BEEF);
    @(negedge clk); check("lit_ctrl_readback", HRDATA, 32'h3F1);
    check("lit_ctrl_fields", {rxbaud, txbaud, irq_en, uart_en}, 32'h7F);
    tick();

    // 0x10 aliases DATA; STATUS is read-only; CTRL must be untouched.
    xfer(1'b1, 12'h010, 32'h0000_0000);
    xfer(1'b1, 12'h004, 32'hFFFF_FFFF);
    xfer(1'b0, 12'h008, 32'h0);
    @(negedge clk); check("lit_ctrl_unchanged", HRDATA, 32'h3F1);
    tick();

    // Selected but IDLE transfer is ignored.
    HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b00; HADDR = 12'h000;
    tick();
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'h5A;
    repeat (2) tick();

    // Back-to-back DATA writes and reads.
    xfer(1'b1, 12'h000, 32'h11);
    xfer(1'b1, 12'h000, 32'h22);
    xfer(1'b1, 12'h000, 32'h33);
    push_rx(8'h81); push_rx(8'h82); push_rx(8'h83);
    tick();
    xfer(1'b0, 12'h000, 32'h0);
    xfer(1'b0, 12'h000, 32'h0);
    xfer(1'b0, 12'h000, 32'h0);
    xfer(1'b0, 12'h000, 32'h0);
    repeat (2) tick();

    // STATUS with tx_flag set and TX FIFO non-empty.
    tx_flag = 1'b1; txfifo_empty = 1'b0;
    tick();
    xfer(1'b0, 12'h004, 32'h0);
    @(negedge clk); check("lit_status", HRDATA, 32'h6);
    tick();
    tx_flag = 1'b0; txfifo_empty = 1'b1;
    repeat (2) tick();

`ifdef UART_REGS_IRQ_STATUS_EN
    xfer(1'b1, 12'h008, 32'h011);
    xfer(1'b1, 12'h00C, 32'hF);
    repeat (2) tick();
    xfer(1'b0, 12'h00C, 32'h0);
    @(negedge clk); check("lit_isr_cleared", HRDATA, 32'h0);
    tick();
    rx_flag = 1'b1;
    repeat (2) tick();
    xfer(1'b0, 12'h00C, 32'h0);
    @(negedge clk); check("lit_isr_rx_set", HRDATA, 32'h1); check("lit_irq_set", irq, 32'h1);
    tick();
    rx_flag = 1'b0;
    xfer(1'b1, 12'h00C, 32'h1);
    repeat (2) tick();
    @(negedge clk); check("lit_irq_cleared", irq, 32'h0);
    tick();
    xfer(1'b0, 12'h00C, 32'h0);
    @(negedge clk); check("lit_isr_w1c", HRDATA, 32'h0);
    tick();
    // New rx_flag edge in the same cycle as the W1C data phase.
    xfer(1'b1, 12'h00C, 32'h1);
    rx_flag = 1'b1;
    repeat (2) tick();
    xfer(1'b0, 12'h00C, 32'h0);
    @(negedge clk); check("lit_isr_set_wins", HRDATA, 32'h1);
    tick();
    rx_flag = 1'b0;
    // Events still latch with interrupts masked.
    xfer(1'b1, 12'h008, 32'h001);
    repeat (2) tick();
    tx_flag = 1'b1;
    repeat (2) tick();
    xfer(1'b0, 12'h00C, 32'h0);
    @(negedge clk); check("lit_isr_masked", HRDATA, 32'h3); check("lit_irq_masked", irq, 32'h0);
    tick();
    tx_flag = 1'b0;
`else
    xfer(1'b1, 12'h00C, 32'hF);
    xfer(1'b0, 12'h00C, 32'h0);
    @(negedge clk); check("lit_isr_absent", HRDATA, 32'h0);
    tick();
    uart_irq = 1'b1;
    tick();
    uart_irq = 1'b0;
    @(negedge clk); check("lit_irq_pulse", irq, 32'h1);
    tick();
    @(negedge clk); check("lit_irq_pulse_end", irq, 32'h0);
    tick();
`endif

    // Reset during a pending DATA write data phase.
    xfer(1'b1, 12'h008, 32'h3F1);
    repeat (2) tick();
    xfer(1'b1, 12'h000, 32'h77);
    pulse_reset(1);
    @(negedge clk);
    check("lit_reset_mid_no_push", wr_txfifo, 32'h0);
    check("lit_reset_mid_wrdata", wrdata, 32'h0);
    check("lit_reset_mid_ctrl", {rxbaud, txbaud, irq_en, uart_en}, 32'h0);
    tick();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_uart_regs.md
# ahb_uart_regs

AHB-Lite slave that gives the Cortex-M0 a register view of the UART peripheral. It is the bus-side initiator for `uart_top`:
- drives `uart_top`'s control inputs (`uart_en`, `irq_en`, `txbaud`, `rxbaud`);
- pushes TX bytes and pops RX bytes;
- folds the UART status and interrupt lines into readable, clearable registers.

It sits between the system AHB interconnect and `uart_top`.

## Interface
Parameters:
- ADDR_W, 12, decoded HADDR width (offsets use HADDR[3:2] only; the upper bits are don't-care inside HSEL).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- HSEL, HWRITE, HREADY  in  1  AHB-Lite select, direction, bus ready
- HTRANS  in  2  transfer type (only HTRANS[1] is used)
- HADDR  in  ADDR_W  address
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HREADYOUT  out  1  tied 1 (no wait states)
- HRESP  out  1  tied 0 (OKAY)
- uart_en  out  1  CTRL[0]
- irq_en  out  4  CTRL[7:4]
- txbaud, rxbaud  out  1  CTRL[8], CTRL[9]
- wr_txfifo  out  1  one-cycle TX push
- wrdata  out  8  TX byte
- rd_rxfifo  out  1  one-cycle RX pop
- rddata  in  8  RX FIFO head, show-ahead
- txfifo_empty, rxfifo_empty, tx_flag, rx_flag, uart_irq  in  1  UART status
- irq  out  1  interrupt to NVIC

## Operation
- **Address-phase capture:** on HSEL & HTRANS[1] & HREADY, latch the address, HWRITE and a valid flag. The data phase is the next cycle. HSIZE is ignored; every access is treated as a word access.
- **0x0 DATA, write:** the cycle after the data phase, wr_txfifo=1 and wrdata=HWDATA[7:0] (both registered).
- **0x0 DATA, read:** HRDATA={24'b0,rddata}. rd_rxfifo=1 combinationally in the same data-phase cycle, only if !rxfifo_empty.
- **0x0 DATA, read while RX empty:** returns 0, no pop.
- **0x4 STATUS (RO):** {28'b0, rx_flag, tx_flag, rxfifo_empty, txfifo_empty}.
- **0x8 CTRL (RW):** bits [9:0] are stored; other bits read 0. Updated at the end of the data phase.
- **0xC ISR:** see Configuration.
- **Unused offsets and bits:** read 0; writes are ignored.
- **HRDATA:** combinational mux of the data-phase address; 0 when no read is in its data phase.
- **Back-to-back transfers:** supported every cycle. A write followed by a read of CTRL returns the new value.

## Timing
- **Reset values:** all outputs 0 except HREADYOUT=1. CTRL=0, ISR=0, irq=0, wr_txfifo=0, rd_rxfifo=0, wrdata=0.
- **Reset mid-transfer:** the pending data phase is discarded; no push or pop is issued.
- **DATA write latency:** address phase at cycle N, HWDATA at N+1, wr_txfifo high for exactly cycle N+2.
- **DATA read latency:** HRDATA valid at N+1. rd_rxfifo high at N+1. The FIFO head advances after the N+1 edge.
- **Consecutive DATA reads:** each read pops one byte in order.
- **Consecutive DATA writes:** each write produces one wr_txfifo pulse, in consecutive cycles.

## Configuration
`UART_REGS_IRQ_STATUS_EN`
- **Defined:** ISR[3:0] holds sticky per-source flags {txe, rxne, tx, rx}.
  - Set events: txfifo_empty 0→1, rxfifo_empty 1→0, tx_flag 0→1, rx_flag 0→1, each detected against a registered copy.
  - Clearing: writing 1 to a bit clears it.
  - Set and clear in the same cycle: set wins.
  - irq = |(ISR[3:0] & irq_en), registered (one-cycle latency from the flag).
  - ISR reflects events even while irq_en is 0.
- **Undefined:** ISR reads 0 and writes to it are ignored. irq = uart_irq registered once (a pulse, one cycle late).

## Structure
- **Package `uart_regs_pkg`:** offsets DATA/STATUS/CTRL/ISR, CTRL field positions, and ISR bit indices.
- **Sub-module `uart_irq_capture`:** edge detectors, sticky ISR and W1C logic. It exists only under the macro.

## Test plan
- **TX push:** write 0xA5 to 0x0 → exactly one wr_txfifo pulse two cycles after the address phase, wrdata=0xA5.
- **RX pop:** rxfifo_empty=0, rddata=0x3C, read 0x0 → HRDATA=0x3C and one rd_rxfifo pulse in the data phase. With rxfifo_empty=1 → HRDATA=0, no pulse.
- **CTRL:** write 0x3F1 to 0x8 → uart_en=1, irq_en=0xF, txbaud=1, rxbaud=1. Read-back 0x3F1. Write to 0x10 → no change.
- **ISR set/clear (macro on):** irq_en=0x1, rx_flag rises → ISR=0x1 and irq=1. Write 0x1 to 0xC → ISR=0, irq=0.
- **Set vs clear (macro on):** W1C of bit0 in the same cycle as a new rx_flag edge → ISR[0] stays 1.
- **Reset during a pending DATA write data phase:** assert rst → no wr_txfifo pulse, all outputs at their reset values.
